tone_generator: RTL

//  Square-wave tone generator; sits directly downstream of the note datapath.

---
 rtl/audio_pkg.sv | 28 ++
 rtl/half_period_counter.sv | 35 +++
 rtl/tone_generator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio tone path: state encoding, defaults, level helper.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned CNT_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic signed [SAMPLE_W-1:0] AMPLITUDE_DEF = 32'sd10000000;
  localparam logic [CNT_W-1:0]           MIN_HALF_DEF  = 32'd2;

  // Square-wave level: silent when not sounding, otherwise +/- amplitude by phase.
  function automatic logic signed [SAMPLE_W-1:0] tone_level(
    input logic                       sounding,
    input logic                       phase,
    input logic signed [SAMPLE_W-1:0] amp
  );
    if (!sounding) begin
      return '0;
    end
    return phase ? amp : -amp;
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// 32-bit down-counter timing one half-period; reload on load, auto-repeat on terminal count.
module half_period_counter
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_len;

  // Count down; a load starts a fresh half-period, reaching zero repeats the last length.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      half_len <= '0;
    end else if (load) begin
      half_len <= load_val;
      cnt      <= load_val - CNT_W'(1);
    end else if (en) begin
      if (cnt == '0) begin
        cnt <= half_len - CNT_W'(1);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/tone_generator.sv
// Click-free square-wave tone generator feeding the stereo codec FIFO.
module tone_generator
  import audio_pkg::*;
#(
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = AMPLITUDE_DEF,
  parameter logic [CNT_W-1:0]           MIN_HALF  = MIN_HALF_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CNT_W-1:0]           freq_in,
  input  logic                       play_en,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic signed [SAMPLE_W-1:0] left_sample,
  output logic signed [SAMPLE_W-1:0] right_sample,
  output logic                       busy
);

  state_t                     state;
  state_t                     state_next;
  logic                       phase;
  logic                       phase_next;
  logic                       load;
  logic                       cnt_en;
  logic                       tc;
  logic                       freq_ok;
  logic                       strobe_next;
  logic signed [SAMPLE_W-1:0] level_c;

  assign freq_ok     = (freq_in >= MIN_HALF);
  assign strobe_next = audio_out_allowed && !write_audio_out;

  half_period_counter u_half_period_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (freq_in),
    .en       (cnt_en),
    .tc       (tc)
  );

  // State and phase registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_next;
      phase <= phase_next;
    end
  end

  // Next state: boundaries are handled before play_en, so a tone only starts/stops on a boundary.
  always_comb begin
    state_next = state;
    phase_next = phase;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (play_en && freq_ok) begin
          state_next = RUN;
          phase_next = 1'b1;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (tc) begin
          if (freq_ok) begin
            load       = 1'b1;
            phase_next = !phase;
            state_next = play_en ? RUN : STOP;
          end else begin
            state_next = IDLE;
            phase_next = 1'b0;
          end
        end else if (!play_en) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (tc) begin
          if (play_en && freq_ok) begin
            load       = 1'b1;
            phase_next = !phase;
            state_next = RUN;
          end else begin
            state_next = IDLE;
            phase_next = 1'b0;
          end
        end else if (play_en) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = 1'b0;
      end
    endcase
  end

  // Counter enable and current output level derived from the registered state.
  always_comb begin
    cnt_en  = (state != IDLE);
    level_c = tone_level(state != IDLE, phase, AMPLITUDE);
  end

  // Codec handshake: strobe at most every other cycle, capturing the level with the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_audio_out <= 1'b0;
      left_sample     <= '0;
      right_sample    <= '0;
      busy            <= 1'b0;
    end else begin
      write_audio_out <= strobe_next;
      if (strobe_next) begin
        left_sample  <= level_c;
        right_sample <= level_c;
      end
      busy <= (state_next != IDLE);
    end
  end

endmodule
